// File: rtl/ahb_slave_mem_ws.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem_ws
//
// AHB-Lite slave memory model with configurable data width and depth,
// byte-lane writes, run-time programmable wait states and saturating
// transfer counters.
//
// Optional feature (macro AHB_SLAVE_MEM_ERRINJ_EN):
//   Transfers that hit the address window (HADDR & ERR_MASK) ==
//   (ERR_BASE & ERR_MASK), with ERR_MASK != 0, or that request an HSIZE
//   wider than the data bus, receive a two-cycle ERROR response
//   (states ERR1/ERR2). Without the macro HRESP is constant 0 and
//   oversize HSIZE is treated as a full-width access.
//
// Ports:
//   HCLK       clock, all logic on the rising edge
//   HRESET     synchronous active-high reset
//   HSEL       slave select
//   HADDR      byte address (AWIDTH)
//   HTRANS     transfer type, bit 1 = NONSEQ/SEQ
//   HWRITE     1 = write
//   HSIZE      transfer size
//   HBURST     accepted and ignored
//   HWDATA     write data for the data phase (DWIDTH)
//   HREADYIN   bus-level HREADY
//   HRDATA     read data, zero outside the DATA state
//   HREADYOUT  slave ready
//   HRESP      0 = OKAY, 1 = ERROR
//   CFG_WAIT   wait states per transfer, sampled at acceptance
//   WR_COUNT   completed OKAY writes, saturating
//   RD_COUNT   completed OKAY reads, saturating
// ---------------------------------------------------------------------------
module ahb_slave_mem_ws #(
  parameter int                AWIDTH   = 12,
  parameter int                DWIDTH   = 32,
  parameter int                DEPTH    = 1024,
  parameter logic [AWIDTH-1:0] ERR_BASE = '0,
  parameter logic [AWIDTH-1:0] ERR_MASK = '0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DWIDTH-1:0] HWDATA,
  input  logic              HREADYIN,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic [3:0]        CFG_WAIT,
  output logic [15:0]       WR_COUNT,
  output logic [15:0]       RD_COUNT
);

  localparam int         NB       = DWIDTH / 8;
  localparam int         LOG2NB   = $clog2(NB);
  localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(LOG2NB);

`ifdef AHB_SLAVE_MEM_ERRINJ_EN
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;
`endif

  state_t            state, state_n;
  logic [3:0]        wait_cnt, wait_cnt_n;
  logic [AWIDTH-1:0] lat_addr;
  logic [2:0]        lat_size;
  logic              lat_write;
  logic              can_accept, accept;
  logic              resp;
  logic [31:0]       word_addr;
  logic [IW-1:0]     idx;
  logic [NB-1:0]     lane_en;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [15:0]       wr_cnt, rd_cnt;

  // HBURST carries no information for this slave: every beat is decoded
  // from HADDR.
  logic unused_bus;
  assign unused_bus = ^HBURST;

`ifdef AHB_SLAVE_MEM_ERRINJ_EN
  logic err_hit;
  assign err_hit = ((ERR_MASK != '0) && ((HADDR & ERR_MASK) == (ERR_BASE & ERR_MASK)))
                || (HSIZE > MAX_SIZE);
`else
  logic unused_err_cfg;
  assign unused_err_cfg = ^{ERR_BASE, ERR_MASK};
`endif

  // Word index wraps modulo DEPTH so any DEPTH (not only powers of two) works.
  assign word_addr = 32'(lat_addr >> LOG2NB);
  assign idx       = IW'(word_addr % DEPTH);

  // Byte lanes for the latched transfer: an aligned group of 2**size bytes.
  // Sizes wider than the bus collapse to a full-width access.
  always_comb begin : lane_decode
    logic [2:0]  eff_size;
    int unsigned nbytes;
    int unsigned first;
    eff_size = (lat_size > MAX_SIZE) ? MAX_SIZE : lat_size;
    nbytes   = 32'd1 << eff_size;
    first    = 32'(lat_addr[LOG2NB-1:0]) & ~(nbytes - 32'd1);
    for (int unsigned b = 0; b < NB; b++) begin
      lane_en[b] = (b >= first) && (b < first + nbytes);
    end
  end

  // State register and address-phase capture.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_write <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (accept) begin
        lat_addr  <= HADDR;
        lat_size  <= HSIZE;
        lat_write <= HWRITE;
      end
    end
  end

  // Next-state and response outputs.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    can_accept = 1'b0;
    HREADYOUT  = 1'b1;
    resp       = 1'b0;
    HRDATA     = '0;

    case (state)
      ST_IDLE: can_accept = 1'b1;
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt <= 4'd1) state_n    = ST_DATA;
        else                  wait_cnt_n = wait_cnt - 4'd1;
      end
      ST_DATA: begin
        can_accept = 1'b1;
        HRDATA     = mem[idx];
      end
`ifdef AHB_SLAVE_MEM_ERRINJ_EN
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        resp      = 1'b1;
        state_n   = ST_ERR2;
      end
      ST_ERR2: begin
        resp       = 1'b1;
        can_accept = 1'b1;
      end
`endif
      default: state_n = ST_IDLE;
    endcase

    accept = can_accept && HSEL && HREADYIN && HTRANS[1];

    // States that end a transfer may start the next one in the same cycle.
    if (can_accept) begin
      if (!accept) begin
        state_n = ST_IDLE;
`ifdef AHB_SLAVE_MEM_ERRINJ_EN
      end else if (err_hit) begin
        // Error responses skip the programmed wait states.
        state_n = ST_ERR1;
`endif
      end else if (CFG_WAIT != 4'd0) begin
        state_n    = ST_WAIT;
        wait_cnt_n = CFG_WAIT;
      end else begin
        state_n = ST_DATA;
      end
    end
  end

  assign HRESP = resp;

  // NOTE: the memory array is deliberately not reset; contents survive
  // HRESET and only the write enable is gated so an aborted transfer
  // cannot commit.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state == ST_DATA) && lat_write) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_en[b]) mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Completed-transfer counters; only OKAY data phases reach ST_DATA.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (state == ST_DATA) begin
      if (lat_write) begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end else begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

  assign WR_COUNT = wr_cnt;
  assign RD_COUNT = rd_cnt;

endmodule

// File: tb/tb_ahb_slave_mem_ws.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mem_ws
//
// Self-checking bench for ahb_slave_mem_ws (32-bit bus, 512 words so that
// 0x804 aliases word 0x004). A pipelined AHB master drives queued transfers;
// read expectations come from a byte-lane reference memory and are pushed to
// a scoreboard at acceptance and popped in the data phase. Error-injection
// scenarios are compiled only when AHB_SLAVE_MEM_ERRINJ_EN is defined.
// ---------------------------------------------------------------------------
module tb_ahb_slave_mem_ws;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int DEP = 512;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          hreset;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic          hreadyin;
  logic [DW-1:0] hrdata;
  logic          hreadyout;
  logic          hresp;
  logic [3:0]    cfg_wait;
  logic [15:0]   wr_count;
  logic [15:0]   rd_count;

  // Single slave on the bus: HREADY is this slave's HREADYOUT.
  assign hreadyin = hreadyout;

  ahb_slave_mem_ws #(
    .AWIDTH  (AW),
    .DWIDTH  (DW),
    .DEPTH   (DEP),
    .ERR_BASE(12'h800),
    .ERR_MASK(12'h800)
  ) dut (
    .HCLK     (clk),
    .HRESET   (hreset),
    .HSEL     (hsel),
    .HADDR    (haddr),
    .HTRANS   (htrans),
    .HWRITE   (hwrite),
    .HSIZE    (hsize),
    .HBURST   (hburst),
    .HWDATA   (hwdata),
    .HREADYIN (hreadyin),
    .HRDATA   (hrdata),
    .HREADYOUT(hreadyout),
    .HRESP    (hresp),
    .CFG_WAIT (cfg_wait),
    .WR_COUNT (wr_count),
    .RD_COUNT (rd_count)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
  } xfer_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEP];
  int unsigned wr_m = 0;
  int unsigned rd_m = 0;
  xfer_t       seq[$];
  logic [31:0] sb[$];

  function automatic xfer_t mk(input logic wr, input logic [AW-1:0] a,
                               input logic [2:0] sz, input logic [31:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.size = sz; x.wdata = d;
    return x;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return (int'(a) >> 2) % DEP;
  endfunction

  // Reference byte-lane write: 2**size aligned bytes, full word for size >= 2.
  function automatic void model_write(input xfer_t x);
    int w, nb, first;
    w     = widx(x.addr);
    nb    = (x.size >= 3'd2) ? 4 : (1 << x.size);
    first = int'(x.addr[1:0]) & ~(nb - 1);
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + nb) model[w][8*b +: 8] = x.wdata[8*b +: 8];
  endfunction

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hwdata = '0;
  endtask

  // Pipelined master: runs every queued transfer, checks wait count, HRESP
  // and read data per data phase. Starts and ends #1 after a rising edge.
  task automatic run_seq(input int exp_wait, input int cfg_after, input string tag);
    xfer_t       dp, ap;
    bit          dp_valid, ap_valid, rdy;
    int          lows, guard;
    logic [31:0] exp;
    dp = '0; ap = '0; dp_valid = 1'b0; lows = 0; guard = 0;
    while ((seq.size() > 0 || dp_valid) && guard < 500) begin
      guard++;
      ap_valid = (seq.size() > 0);
      if (ap_valid) ap = seq[0];
      hsel   = ap_valid;
      htrans = ap_valid ? 2'b10 : 2'b00;
      haddr  = ap_valid ? ap.addr : '0;
      hwrite = ap_valid && ap.wr;
      hsize  = ap_valid ? ap.size : 3'd2;
      hwdata = dp_valid ? dp.wdata : '0;
      @(negedge clk);
      rdy = hreadyout;
      if (dp_valid && !rdy) lows++;
      if (dp_valid && rdy) begin
        checks++;
        if (lows !== exp_wait) begin
          errors++;
          $display("FAIL %s wait_cycles addr=%h: got %0d expected %0d", tag, dp.addr, lows, exp_wait);
        end
        checks++;
        if (hresp !== 1'b0) begin
          errors++;
          $display("FAIL %s hresp addr=%h: got %b expected 0", tag, dp.addr, hresp);
        end
        if (!dp.wr) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty addr=%h: got %h expected none", tag, dp.addr, hrdata);
          end else begin
            exp = sb.pop_front();
            if (hrdata !== exp) begin
              errors++;
              $display("FAIL %s hrdata addr=%h: got %h expected %h", tag, dp.addr, hrdata, exp);
            end
          end
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (dp_valid) begin
          if (dp.wr) begin model_write(dp); wr_m++; end
          else rd_m++;
        end
        dp_valid = ap_valid;
        if (ap_valid) begin
          dp   = seq.pop_front();
          lows = 0;
          if (!dp.wr) sb.push_back(model[widx(dp.addr)]);
          if (cfg_after >= 0) cfg_wait = 4'(cfg_after);
        end
      end
    end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d cycles expected < 500", tag, guard);
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    cfg_wait = 4'd0;
    hreset   = 1'b1;
    repeat (2) @(posedge clk);
    #1 hreset = 1'b0;
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b expected 1", hreadyout); end
    checks++; if (hresp !== 1'b0)     begin errors++; $display("FAIL reset_hresp: got %b expected 0", hresp); end
    checks++; if (hrdata !== 32'h0)   begin errors++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
    checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    cfg_wait = 4'd0;
    seq.push_back(mk(1'b1, 12'h010, 3'd2, 32'h12345678));
    seq.push_back(mk(1'b0, 12'h010, 3'd2, 32'h0));
    run_seq(0, -1, "b2b");
    @(negedge clk);
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 1", wr_count); end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL b2b_rd_count: got %0d expected 1", rd_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states();
    cfg_wait = 4'd3;
    seq.push_back(mk(1'b0, 12'h010, 3'd2, 32'h0));
    run_seq(3, -1, "wait3");
  endtask

  task automatic test_byte_lanes();
    cfg_wait = 4'd0;
    seq.push_back(mk(1'b1, 12'h012, 3'd0, 32'h00AB0000));
    seq.push_back(mk(1'b0, 12'h010, 3'd2, 32'h0));
    seq.push_back(mk(1'b1, 12'h014, 3'd2, 32'h55667788));
    seq.push_back(mk(1'b1, 12'h016, 3'd1, 32'hBEEF0000));
    seq.push_back(mk(1'b1, 12'h015, 3'd0, 32'h0000C300));
    seq.push_back(mk(1'b0, 12'h014, 3'd2, 32'h0));
    run_seq(0, -1, "lanes");
  endtask

  task automatic test_cfg_change();
    cfg_wait = 4'd2;
    seq.push_back(mk(1'b0, 12'h014, 3'd2, 32'h0));
    run_seq(2, 0, "cfg_change");
  endtask

  task automatic test_burst();
    cfg_wait = 4'd1;
    for (int i = 0; i < 6; i++)
      seq.push_back(mk(1'b1, 12'(12'h100 + 4 * i), 3'd2, $urandom()));
    seq.push_back(mk(1'b1, 12'h200, 3'd2, 32'hA5A5_5A5A));
    seq.push_back(mk(1'b0, 12'h200, 3'd2, 32'h0));
    for (int i = 0; i < 6; i++)
      seq.push_back(mk(1'b0, 12'(12'h100 + 4 * i), 3'd2, 32'h0));
    run_seq(1, -1, "burst");
    @(negedge clk);
    checks++; if (wr_count !== 16'(wr_m)) begin errors++; $display("FAIL burst_wr_count: got %0d expected %0d", wr_count, wr_m); end
    checks++; if (rd_count !== 16'(rd_m)) begin errors++; $display("FAIL burst_rd_count: got %0d expected %0d", rd_count, rd_m); end
    @(posedge clk); #1;
  endtask

`ifdef AHB_SLAVE_MEM_ERRINJ_EN
  task automatic test_error_inject();
    logic [AW-1:0] ea [2];
    logic [2:0]    es [2];
    ea[0] = 12'h804; es[0] = 3'd2;   // address-window hit, aliases word 0x004
    ea[1] = 12'h008; es[1] = 3'd3;   // oversize HSIZE on a 32-bit bus
    cfg_wait = 4'd0;
    seq.push_back(mk(1'b1, 12'h004, 3'd2, 32'hCAFEF00D));
    seq.push_back(mk(1'b1, 12'h008, 3'd2, 32'h13579BDF));
    run_seq(0, -1, "err_setup");
    cfg_wait = 4'd2;
    for (int i = 0; i < 2; i++) begin
      hsel = 1'b1; htrans = 2'b10; haddr = ea[i]; hwrite = 1'b1; hsize = es[i];
      @(posedge clk); #1;
      drive_idle();
      hwdata = 32'h0BAD_BAD0;
      @(negedge clk);
      checks++; if (hresp !== 1'b1)     begin errors++; $display("FAIL err1_hresp %0d: got %b expected 1", i, hresp); end
      checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL err1_hreadyout %0d: got %b expected 0", i, hreadyout); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (hresp !== 1'b1)     begin errors++; $display("FAIL err2_hresp %0d: got %b expected 1", i, hresp); end
      checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL err2_hreadyout %0d: got %b expected 1", i, hreadyout); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (hresp !== 1'b0)         begin errors++; $display("FAIL err_idle_hresp %0d: got %b expected 0", i, hresp); end
      checks++; if (wr_count !== 16'(wr_m)) begin errors++; $display("FAIL err_wr_count %0d: got %0d expected %0d", i, wr_count, wr_m); end
      @(posedge clk); #1;
    end
    seq.push_back(mk(1'b0, 12'h004, 3'd2, 32'h0));
    seq.push_back(mk(1'b0, 12'h008, 3'd2, 32'h0));
    run_seq(2, -1, "err_readback");
  endtask
`endif

  task automatic test_reset_mid();
    cfg_wait = 4'd0;
    seq.push_back(mk(1'b1, 12'h020, 3'd2, 32'h11111111));
    run_seq(0, -1, "rst_setup");
    cfg_wait = 4'd3;
    hsel = 1'b1; htrans = 2'b10; haddr = 12'h020; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    drive_idle();
    hwdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL rst_mid_in_wait: got %b expected 0", hreadyout); end
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    hwdata = '0;
    wr_m = 0; rd_m = 0;
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rst_mid_hreadyout: got %b expected 1", hreadyout); end
    checks++; if (hresp !== 1'b0)     begin errors++; $display("FAIL rst_mid_hresp: got %b expected 0", hresp); end
    checks++; if (hrdata !== 32'h0)   begin errors++; $display("FAIL rst_mid_hrdata: got %h expected 0", hrdata); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL rst_mid_wr_count: got %0d expected 0", wr_count); end
    checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL rst_mid_rd_count: got %0d expected 0", rd_count); end
    @(posedge clk); #1;
    cfg_wait = 4'd0;
    seq.push_back(mk(1'b0, 12'h020, 3'd2, 32'h0));
    run_seq(0, -1, "rst_readback");
    @(negedge clk);
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL rst_after_wr_count: got %0d expected 0", wr_count); end
    checks++; if (rd_count !== 16'h1) begin errors++; $display("FAIL rst_after_rd_count: got %0d expected 1", rd_count); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) model[i] = '0;
    hreset = 1'b1;
    cfg_wait = 4'd0;
    drive_idle();
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_cfg_change();
    test_burst();
`ifdef AHB_SLAVE_MEM_ERRINJ_EN
    test_error_inject();
`endif
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
